// File: rtl/qif_spike_decoder_if.sv
// -----------------------------------------------------------------------------
// qif_spike_decoder_if
// Bundles the data-path signals of the spike decoder.
//   en_i         : count enable (low freezes all decoder state)
//   v_i          : 8-bit unsigned membrane potential
//   spike_o      : one-cycle pulse per detected spike
//   isi_o        : cycles between the last two spikes, saturating at 255
//   rate_o       : spikes in the last completed window, saturating at 255
//   rate_valid_o : one-cycle pulse when rate_o is updated
// slave modport faces the decoder, master modport faces the neuron/consumer.
// -----------------------------------------------------------------------------
interface qif_spike_decoder_if;
   logic       en_i;
   logic [7:0] v_i;
   logic       spike_o;
   logic [7:0] isi_o;
   logic [7:0] rate_o;
   logic       rate_valid_o;

   modport slave (
      input  en_i,
      input  v_i,
      output spike_o,
      output isi_o,
      output rate_o,
      output rate_valid_o
   );

   modport master (
      output en_i,
      output v_i,
      input  spike_o,
      input  isi_o,
      input  rate_o,
      input  rate_valid_o
   );
endinterface

// File: rtl/qif_spike_decoder.sv
// -----------------------------------------------------------------------------
// qif_spike_decoder
// Turns the membrane potential of a quadratic integrate-and-fire neuron into
// spike events, an inter-spike interval and a windowed spike rate.
// Ports:
//   clk : single rising-edge clock
//   rst : asynchronous, active-high reset
//   bus : qif_spike_decoder_if.slave (en_i, v_i in; spike_o, isi_o, rate_o,
//         rate_valid_o out, all registered)
// -----------------------------------------------------------------------------
module qif_spike_decoder #(
   parameter logic [7:0]  V_PEAK     = 8'd200,
   parameter logic [7:0]  V_RESET    = 8'd64,
   parameter int          REFRAC_CYC = 4,
   parameter logic [15:0] WINDOW     = 16'd1000
) (
   input logic                  clk,
   input logic                  rst,
   qif_spike_decoder_if.slave   bus
);

   typedef enum logic [0:0] {
      ARMED      = 1'b0,
      REFRACTORY = 1'b1
   } state_t;

   localparam logic [7:0]  REFRAC_LD = 8'(REFRAC_CYC);
   localparam logic [15:0] WIN_LAST  = WINDOW - 16'd1;

   // Saturating 8-bit add of a single-bit increment.
   function automatic logic [7:0] sat_inc(input logic [7:0] a, input logic b);
      logic [8:0] s;
      s = {1'b0, a} + {8'd0, b};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

   state_t      state_q;
   logic [7:0]  v_q;
   logic [7:0]  ref_q;
   logic        spike_q;
   logic [7:0]  isi_cnt_q, isi_cnt_d;
   logic [7:0]  isi_q,     isi_d;
   logic [15:0] win_q,     win_d;
   logic [7:0]  spk_cnt_q, spk_cnt_d;
   logic [7:0]  rate_q,    rate_d;
   logic        rate_valid_q, rate_valid_d;
   logic        detect_s;

   // Spike is being detected on this edge (same condition the FSM uses).
   assign detect_s = bus.en_i && (state_q == ARMED) && (v_q >= V_PEAK);

   // Input sample register; runs even while disabled so a pending spike is
   // seen as soon as en returns.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= 8'd0;
      end else begin
         v_q <= bus.v_i;
      end
   end

   // Detector FSM with refractory counter and registered spike pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ARMED;
         ref_q   <= 8'd0;
         spike_q <= 1'b0;
      end else if (!bus.en_i) begin
         spike_q <= 1'b0;
      end else begin
         case (state_q)
            ARMED: begin
               if (v_q >= V_PEAK) begin
                  state_q <= REFRACTORY;
                  ref_q   <= REFRAC_LD;
                  spike_q <= 1'b1;
               end else begin
                  spike_q <= 1'b0;
               end
            end
            REFRACTORY: begin
               spike_q <= 1'b0;
               // Re-arm needs both the hold-off elapsed and V back below reset.
               if (ref_q == 8'd0) begin
                  if (v_q < V_RESET) begin
                     state_q <= ARMED;
                  end else begin
                     state_q <= REFRACTORY;
                  end
               end else begin
                  ref_q <= ref_q - 8'd1;
               end
            end
            default: begin
               state_q <= ARMED;
               ref_q   <= 8'd0;
               spike_q <= 1'b0;
            end
         endcase
      end
   end

   // Next-state logic for the ISI, window and rate counters.
   always_comb begin
      isi_cnt_d    = isi_cnt_q;
      isi_d        = isi_q;
      win_d        = win_q;
      spk_cnt_d    = spk_cnt_q;
      rate_d       = rate_q;
      rate_valid_d = 1'b0;
      if (bus.en_i) begin
         // The detection cycle itself is counted, so isi equals the spacing
         // in cycles between consecutive spike pulses.
         if (detect_s) begin
            isi_d     = sat_inc(isi_cnt_q, 1'b1);
            isi_cnt_d = 8'd0;
         end else begin
            isi_cnt_d = sat_inc(isi_cnt_q, 1'b1);
         end
         // A spike visible in the last window cycle closes with that window.
         if (win_q == WIN_LAST) begin
            win_d        = 16'd0;
            rate_d       = sat_inc(spk_cnt_q, spike_q);
            spk_cnt_d    = 8'd0;
            rate_valid_d = 1'b1;
         end else begin
            win_d     = win_q + 16'd1;
            spk_cnt_d = sat_inc(spk_cnt_q, spike_q);
         end
      end else begin
         rate_valid_d = 1'b0;
      end
   end

   // Counter and output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         isi_cnt_q    <= 8'hFF;
         isi_q        <= 8'd0;
         win_q        <= 16'd0;
         spk_cnt_q    <= 8'd0;
         rate_q       <= 8'd0;
         rate_valid_q <= 1'b0;
      end else begin
         isi_cnt_q    <= isi_cnt_d;
         isi_q        <= isi_d;
         win_q        <= win_d;
         spk_cnt_q    <= spk_cnt_d;
         rate_q       <= rate_d;
         rate_valid_q <= rate_valid_d;
      end
   end

   assign bus.spike_o      = spike_q;
   assign bus.isi_o        = isi_q;
   assign bus.rate_o       = rate_q;
   assign bus.rate_valid_o = rate_valid_q;

endmodule

// File: tb/tb_qif_spike_decoder.sv
// -----------------------------------------------------------------------------
// tb_qif_spike_decoder
// Directed bench for qif_spike_decoder with default parameters
// (V_PEAK=200, V_RESET=64, REFRAC_CYC=4, WINDOW=1000). Cycle c below means
// the c-th rising edge after reset release; V for cycle c is applied before
// that edge and outputs are sampled 1 time unit after it.
// -----------------------------------------------------------------------------
module tb_qif_spike_decoder;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   qif_spike_decoder_if bus ();

   qif_spike_decoder dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      bus.en_i   = 1'b0;
      bus.v_i    = 8'd0;
      repeat (2) @(posedge clk);
      #1;
      rst      = 1'b0;
      bus.en_i = 1'b1;
   endtask

   // Outputs must stay zero while reset is held, whatever the inputs do.
   task automatic test_reset();
      bus.en_i = 1'b1;
      bus.v_i  = 8'd250;
      rst      = 1'b1;
      repeat (3) tick();
      n_checks++;
      if ({bus.spike_o, bus.rate_valid_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_pulses: spike=%0b rate_valid=%0b required 0 0", bus.spike_o, bus.rate_valid_o);
      end
      n_checks++;
      if ({bus.isi_o, bus.rate_o} !== 16'h0000) begin
         n_fail++;
         $display("FAIL reset_values: isi=%0d rate=%0d required 0 0", bus.isi_o, bus.rate_o);
      end
   endtask

   // V=0 for 2000 cycles: no spikes, rate_valid at 1000 and 2000 with rate 0.
   task automatic test_idle();
      int spikes = 0;
      int rv_bad = 0;
      int rv_cnt = 0;
      do_reset();
      for (int c = 1; c <= 2000; c++) begin
         bus.v_i = 8'd0;
         tick();
         if (bus.spike_o === 1'b1) spikes++;
         if (bus.rate_valid_o === 1'b1) begin
            rv_cnt++;
            if (!((c == 1000) || (c == 2000)) || (bus.rate_o !== 8'd0)) rv_bad++;
         end
      end
      n_checks++;
      if (spikes !== 0) begin
         n_fail++;
         $display("FAIL idle_spikes: got %0d required 0", spikes);
      end
      n_checks++;
      if ((rv_cnt !== 2) || (rv_bad !== 0)) begin
         n_fail++;
         $display("FAIL idle_rate_valid: pulses=%0d misplaced=%0d required 2 0", rv_cnt, rv_bad);
      end
   endtask

   // V=199 never spikes; step to 200 spikes once, two edges after the step.
   task automatic test_step();
      int bad = 0;
      do_reset();
      for (int c = 1; c <= 80; c++) begin
         bus.v_i = (c <= 20) ? 8'd199 : 8'd200;
         tick();
         if (bus.spike_o !== ((c == 22) ? 1'b1 : 1'b0)) bad++;
         if (c == 22) begin
            n_checks++;
            if (bus.isi_o !== 8'd255) begin
               n_fail++;
               $display("FAIL step_first_isi: got %0d required 255", bus.isi_o);
            end
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL step_spike_pattern: mismatched_cycles=%0d required 0", bad);
      end
   endtask

   // Period-10 drive: spike every 10 cycles, isi 10, rate 100 per window.
   task automatic test_period();
      int bad = 0;
      int rv_cnt = 0;
      logic exp_s;
      do_reset();
      for (int c = 1; c <= 1000; c++) begin
         bus.v_i = (((c - 1) % 10) < 2) ? 8'd250 : 8'd10;
         tick();
         exp_s = ((c >= 2) && (((c - 2) % 10) == 0)) ? 1'b1 : 1'b0;
         if (bus.spike_o !== exp_s) bad++;
         if (bus.rate_valid_o === 1'b1) rv_cnt++;
         if (c == 12) begin
            n_checks++;
            if (bus.isi_o !== 8'd10) begin
               n_fail++;
               $display("FAIL period_isi: got %0d required 10", bus.isi_o);
            end
         end
         if (c == 1000) begin
            n_checks++;
            if ((bus.rate_valid_o !== 1'b1) || (bus.rate_o !== 8'd100)) begin
               n_fail++;
               $display("FAIL period_rate: rate_valid=%0b rate=%0d required 1 100", bus.rate_valid_o, bus.rate_o);
            end
         end
      end
      n_checks++;
      if ((bad !== 0) || (rv_cnt !== 1)) begin
         n_fail++;
         $display("FAIL period_pattern: mismatched_cycles=%0d rv_pulses=%0d required 0 1", bad, rv_cnt);
      end
   endtask

   // Re-arm through V=63 after the hold-off; V=64 exactly never re-arms.
   task automatic test_refractory();
      int bad = 0;
      logic [7:0] v;
      do_reset();
      for (int c = 1; c <= 60; c++) begin
         if (c <= 3)       v = 8'd0;
         else if (c <= 5)  v = 8'd250;
         else if (c <= 10) v = 8'd63;
         else if (c <= 15) v = 8'd250;
         else if (c <= 45) v = 8'd64;
         else              v = 8'd250;
         bus.v_i = v;
         tick();
         if (bus.spike_o !== (((c == 5) || (c == 12)) ? 1'b1 : 1'b0)) bad++;
         if (c == 12) begin
            n_checks++;
            if (bus.isi_o !== 8'd7) begin
               n_fail++;
               $display("FAIL refrac_isi: got %0d required 7", bus.isi_o);
            end
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL refrac_pattern: mismatched_cycles=%0d required 0", bad);
      end
   endtask

   // Spike in window cycle 999 closes with that window; next window is empty.
   task automatic test_window_edge();
      int bad = 0;
      do_reset();
      for (int c = 1; c <= 2000; c++) begin
         bus.v_i = ((c >= 998) && (c <= 1000)) ? 8'd250 : 8'd0;
         tick();
         if (bus.spike_o !== ((c == 999) ? 1'b1 : 1'b0)) bad++;
         if (bus.rate_valid_o !== (((c == 1000) || (c == 2000)) ? 1'b1 : 1'b0)) bad++;
         if (c == 1000) begin
            n_checks++;
            if (bus.rate_o !== 8'd1) begin
               n_fail++;
               $display("FAIL edge_rate_close: got %0d required 1", bus.rate_o);
            end
         end
         if (c == 2000) begin
            n_checks++;
            if (bus.rate_o !== 8'd0) begin
               n_fail++;
               $display("FAIL edge_rate_next: got %0d required 0", bus.rate_o);
            end
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL edge_pattern: mismatched_cycles=%0d required 0", bad);
      end
   endtask

   // en low for 50 cycles: window closes 50 late, pending spike fires on return.
   task automatic test_enable_hold();
      int bad = 0;
      do_reset();
      for (int c = 1; c <= 1100; c++) begin
         bus.en_i = ((c >= 501) && (c <= 550)) ? 1'b0 : 1'b1;
         bus.v_i  = ((c >= 520) && (c <= 551)) ? 8'd250 : 8'd0;
         tick();
         if (bus.spike_o !== ((c == 551) ? 1'b1 : 1'b0)) bad++;
         if (bus.rate_valid_o !== ((c == 1050) ? 1'b1 : 1'b0)) bad++;
         if ((c >= 501) && (c <= 550) && ((bus.isi_o !== 8'd0) || (bus.rate_o !== 8'd0))) bad++;
         if (c == 1050) begin
            n_checks++;
            if (bus.rate_o !== 8'd1) begin
               n_fail++;
               $display("FAIL hold_rate: got %0d required 1", bus.rate_o);
            end
         end
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL hold_pattern: mismatched_cycles=%0d required 0", bad);
      end
      bus.en_i = 1'b1;
   endtask

   // Async reset after 7 spikes clears outputs at once; next window only
   // reports post-reset spikes.
   task automatic test_reset_mid();
      int bad = 0;
      do_reset();
      for (int c = 1; c <= 62; c++) begin
         bus.v_i = (((c - 1) % 10) < 2) ? 8'd250 : 8'd10;
         tick();
      end
      n_checks++;
      if ((bus.spike_o !== 1'b1) || (bus.isi_o !== 8'd10)) begin
         n_fail++;
         $display("FAIL rstmid_before: spike=%0b isi=%0d required 1 10", bus.spike_o, bus.isi_o);
      end
      #2;
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.spike_o, bus.isi_o, bus.rate_o, bus.rate_valid_o} !== 18'd0) begin
         n_fail++;
         $display("FAIL rstmid_async: spike=%0b isi=%0d rate=%0d rate_valid=%0b required all 0",
                  bus.spike_o, bus.isi_o, bus.rate_o, bus.rate_valid_o);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int c = 1; c <= 1000; c++) begin
         bus.v_i = ((c <= 30) && (((c - 1) % 10) < 2)) ? 8'd250 : 8'd10;
         tick();
         if (bus.rate_valid_o !== ((c == 1000) ? 1'b1 : 1'b0)) bad++;
      end
      n_checks++;
      if ((bad !== 0) || (bus.rate_o !== 8'd3)) begin
         n_fail++;
         $display("FAIL rstmid_rate: rv_mismatches=%0d rate=%0d required 0 3", bad, bus.rate_o);
      end
   endtask

   initial begin
      bus.en_i = 1'b0;
      bus.v_i  = 8'd0;
      test_reset();
      test_idle();
      test_step();
      test_period();
      test_refractory();
      test_window_edge();
      test_enable_hold();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/qif_spike_decoder.md
QIF_SPIKE_DECODER -- requirements
Module: qif_spike_decoder

Interface
REQ-001 Parameter V_PEAK, default 8'd200: membrane level (unsigned) at or above which a spike is detected.
REQ-002 Parameter V_RESET, default 8'd64: membrane level strictly below which the detector re-arms.
REQ-003 Parameter REFRAC_CYC, default 4: minimum cycles in REFRACTORY before re-arming, range 1..255.
REQ-004 Parameter WINDOW, default 16'd1000: rate window length in enabled cycles, range 2..65535.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 en  input  1  count enable; when low all state holds.
REQ-008 V  input  8  unsigned membrane potential from the neuron's V output.
REQ-009 spike  output  1  one-cycle pulse per detected spike.
REQ-010 isi  output  8  cycles between the last two spikes, saturating.
REQ-011 rate  output  8  spikes counted in the last completed window, saturating.
REQ-012 rate_valid  output  1  one-cycle pulse when rate is updated.

Function
REQ-013 V SHALL be registered into v_q on every clock edge regardless of en; all detection SHALL use v_q.
REQ-014 Detector FSM SHALL have two states: ARMED and REFRACTORY; reset state ARMED.
REQ-015 In ARMED with en=1 and v_q >= V_PEAK, FSM SHALL go to REFRACTORY and spike SHALL be 1 for the following cycle only.
REQ-016 Latency: spike SHALL rise on the 2nd rising edge after the first edge that samples V >= V_PEAK (en held 1).
REQ-017 On entering REFRACTORY a refractory counter SHALL load REFRAC_CYC and decrement each enabled cycle, stopping at 0.
REQ-018 REFRACTORY SHALL return to ARMED only when counter = 0 and v_q < V_RESET, same enabled cycle; v_q >= V_PEAK in REFRACTORY SHALL NOT spike.
REQ-019 v_q = V_RESET exactly SHALL NOT re-arm; v_q = V_PEAK exactly SHALL spike.
REQ-020 An ISI counter SHALL increment each enabled cycle, saturating at 255; on each spike isi SHALL load the counter value and the counter SHALL clear to 0.
REQ-021 Window counter SHALL count 0..WINDOW-1 over enabled cycles and wrap to 0.
REQ-022 Spike counter SHALL increment each enabled cycle where spike=1, saturating at 255.
REQ-023 On the enabled cycle with window counter = WINDOW-1: rate SHALL load spike count plus current spike (saturating 255), spike count SHALL clear, rate_valid SHALL pulse for the next cycle.
REQ-024 A spike in the final window cycle SHALL count in the closing window, never the next one.
REQ-025 With en=0: FSM, all counters, isi and rate hold; spike and rate_valid SHALL be 0; a pending spike is not lost, it appears the first cycle after en returns high if still detected.
REQ-026 All outputs SHALL be registered; no combinational path from V or en to outputs.

Reset
REQ-027 While rst=1, regardless of clk: v_q=0, FSM=ARMED, refractory counter=0, ISI counter=255, window counter=0, spike count=0, spike=0, isi=0, rate=0, rate_valid=0.
REQ-028 rst asserted mid-window or mid-refractory SHALL discard partial counts; no rate_valid SHALL be produced for the aborted window.
REQ-029 First window after reset release SHALL end WINDOW enabled cycles after the first enabled edge.

Verification
REQ-030 Reset then en=1, V=0 for 2000 cycles -> spike never asserts; rate_valid pulses at cycles 1000 and 2000 with rate=0.
REQ-031 V steps 0->200 held -> exactly one spike, 2 edges after step; no second spike while V stays 200.
REQ-032 V alternates 250 for 2 cycles, 10 for 8 cycles (period 10) -> spike every 10 cycles, isi=10 after 2nd spike, rate=100 per 1000-cycle window.
REQ-033 V drops to 63 one cycle after a spike then returns to 250 -> next spike no earlier than REFRAC_CYC+ re-arm cycles; V=64 held instead -> no re-arm, no spike.
REQ-034 Spike timed on window cycle 999 -> counted in rate of that window; next window starts at 0; en=0 for 50 cycles mid-window -> window closes 50 cycles late, all outputs frozen, spike/rate_valid 0.
REQ-035 rst pulsed asynchronously mid-window with 7 spikes counted -> all outputs 0 immediately; next rate_valid after 1000 enabled cycles reports only post-reset spikes.
